bus_fabric: RTL and testbench
=============================

# bus_fabric

Parametrised two-host memory interconnect between the CPU's instruction and data request/grant/rvalid ports and N memory-mapped targets (ROM, FRAM, RAM, GPIO, …) using the valid/ready target protocol. It generalises per-SoC address decoding and the one-cycle response delay into a reusable block. It adds:

- per-target base/mask decode;
- per-target round-robin arbitration between the two hosts;
- execute-permission checking;
- error responses for unmapped accesses;
- a per-host ready-timeout.

## Interface

Parameters:

- N_SLAVES, 4, number of targets (1–8).
- SLAVE_BASE, {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, packed N_SLAVES×32 base addresses; target k uses bits [32k+31:32k].
- SLAVE_MASK, {32'hFFFF_F000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000}, packed N_SLAVES×32 decode masks.
- SLAVE_EXEC, 4'b0001, bit k set means the instruction port may access target k.
- TIMEOUT_CYCLES, 255, maximum wait for target ready; 0 disables the timeout. The counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:

- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- i_req, i_addr  in  1, 32  instruction request and word address.
- i_gnt  out  1  instruction request accepted this cycle.
- i_rvalid, i_rdata, i_err  out  1, 32, 1  registered instruction response.
- d_req, d_we, d_be, d_addr, d_wdata  in  1, 1, 4, 32, 32  data request.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid, d_rdata, d_err  out  1, 32, 1  registered data response.
- s_valid  out  N_SLAVES  per-target request.
- s_addr, s_wdata  out  N_SLAVES×32  per-target address and write data.
- s_wstrb  out  N_SLAVES×4  write strobes; all zero for reads.
- s_rdata  in  N_SLAVES×32  per-target read data.
- s_ready  in  N_SLAVES  per-target completion.

## Operation

- **Decode:** target k hits when (addr & MASK[k]) == BASE[k]. On overlap the lowest hitting index wins. A request with no hit is unmapped.
- **Instruction-port writes:** the instruction port never writes. Its s_wstrb is 4'b0000.
- **Data-port strobes:** s_wstrb = d_we ? d_be : 4'b0000.
- **Ownership:** each target has an owner register: NONE, I or D.
  - A target with owner NONE and exactly one requesting host takes that host as owner.
  - With both hosts requesting, the target's round-robin bit picks the owner. The bit resets to D and flips to the other host after every contested grant.
  - s_valid[k], s_addr, s_wdata and s_wstrb are driven from the owning host's live inputs. This holds both in the cycle ownership is won and while it is held.
  - Ownership persists until the owner's gnt, or its timeout, then returns to NONE.
  - A non-owner requesting a busy target waits and is not granted.
- **Grant:** host gnt = s_valid[k] & s_ready[k] for its target, combinational. In the following cycle rvalid=1, rdata = captured s_rdata[k] (0 for writes) and err=0.
- **Unmapped access, or instruction access to a target with SLAVE_EXEC[k]=0:**
  - gnt is asserted in the same cycle as req.
  - No s_valid is driven.
  - Next cycle: rvalid=1, err=1, rdata=0.
- **Timeout:**
  - Per-host counter. It increments each cycle that req=1 and gnt=0, and clears on gnt or when req=0.
  - When the counter equals TIMEOUT_CYCLES, gnt is asserted in that cycle with s_valid forced to 0, and ownership is released.
  - Next cycle: rvalid=1, err=1, rdata=0.
- **Host independence:** both hosts may be granted in the same cycle when they target different targets.

## Timing

- **Reset values:**
  - i_gnt, d_gnt: 0.
  - i_rvalid, d_rvalid, i_err, d_err: 0.
  - i_rdata, d_rdata: 0.
  - s_valid: all 0.
  - Owners: NONE.
  - Round-robin bits: D.
  - Counters: 0.
- **Reset mid-transaction:** reset asserted while a target is owned drops s_valid immediately, asynchronously. No response is ever issued for the aborted request.
- **Latency:**
  - Zero-wait target (ready in the same cycle as valid): gnt in cycle 0, rvalid in cycle 1.
  - Each cycle of target wait state adds one cycle.
- **Back-to-back requests:** a new req in the cycle after gnt is accepted; its rvalid coincides with the previous response cycle + 1. The throughput is one transfer per cycle per host.
- **Response pulse:** rvalid is a single-cycle pulse. rdata and err are valid only while rvalid=1 and hold their value otherwise.
- **Host rule:** the host must keep req and its payload stable until gnt. Behaviour on withdrawal before gnt: ownership is released the cycle req drops, and no response is issued.
- **TIMEOUT_CYCLES=0:** the counters never fire, and a target that never asserts ready stalls the host indefinitely.

## Test plan

- **Zero-wait read:** d_req read of 32'h2000_0010 with RAM s_ready=1 and s_rdata=32'hDEAD_BEEF → d_gnt in cycle 0, s_valid[2]=1; d_rvalid=1 with d_rdata=32'hDEAD_BEEF and d_err=0 in cycle 1.
- **Contention and round-robin:** i_req and d_req both target ROM (32'h0000_0100, 32'h0000_0200), and ROM ready asserts after 2 wait cycles → D is granted first. The next contested access grants I. Neither host ever sees gnt while the other owns the target.
- **Unmapped access:** d_req read of 32'h8000_0000 → d_gnt in the same cycle, no s_valid. Next cycle: d_rvalid=1, d_err=1, d_rdata=0.
- **Exec violation:** i_req to 32'h1000_0000 (FRAM, SLAVE_EXEC[1]=0) → i_gnt immediately, no s_valid[1]. Next cycle: i_rvalid=1, i_err=1.
- **Timeout:** with TIMEOUT_CYCLES=4, d_req to GPIO and s_ready[3] held 0 → d_gnt in the 5th cycle of the request with s_valid[3]=0 in that cycle. Then d_rvalid=1 and d_err=1. A subsequent instruction request is unaffected.
- **Reset mid-transaction:** with a FRAM write stalled (s_valid[1]=1, wstrb=4'b0011), assert reset → s_valid[1]=0 the same cycle, all outputs at reset values, and no rvalid after release.

Source files
------------

// File: rtl/bus_fabric.sv
`default_nettype none
// ============================================================================
// Module      : bus_fabric
// Description : Two-host (instruction / data) interconnect to N memory-mapped
//               targets using a valid/ready target protocol. Provides
//               base/mask address decode, per-target round-robin ownership,
//               execute-permission checks, error responses for unmapped
//               accesses and a per-host ready timeout. Responses are
//               registered one cycle after the grant.
// Ports       : clk, reset                 - clock, async active-high reset
//               i_req/i_addr -> i_gnt      - instruction request / accept
//               i_rvalid/i_rdata/i_err     - instruction response
//               d_req/d_we/d_be/d_addr/d_wdata -> d_gnt - data request
//               d_rvalid/d_rdata/d_err     - data response
//               s_valid/s_addr/s_wdata/s_wstrb - per-target request
//               s_rdata/s_ready            - per-target read data / done
// Revision    : 1.0 - initial release
// ============================================================================
module bus_fabric #(
  parameter int                       N_SLAVES       = 4,
  parameter logic [N_SLAVES*32-1:0]   SLAVE_BASE     = {32'h4000_0000, 32'h2000_0000,
                                                        32'h1000_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0]   SLAVE_MASK     = {32'hFFFF_F000, 32'hFF00_0000,
                                                        32'hFF00_0000, 32'hFF00_0000},
  parameter logic [N_SLAVES-1:0]      SLAVE_EXEC     = 4'b0001,
  parameter int                       TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  // instruction host
  input  logic                     i_req,
  input  logic [31:0]              i_addr,
  output logic                     i_gnt,
  output logic                     i_rvalid,
  output logic [31:0]              i_rdata,
  output logic                     i_err,
  // data host
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [3:0]               d_be,
  input  logic [31:0]              d_addr,
  input  logic [31:0]              d_wdata,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [31:0]              d_rdata,
  output logic                     d_err,
  // targets
  output logic [N_SLAVES-1:0]      s_valid,
  output logic [N_SLAVES*32-1:0]   s_addr,
  output logic [N_SLAVES*32-1:0]   s_wdata,
  output logic [N_SLAVES*4-1:0]    s_wstrb,
  input  logic [N_SLAVES*32-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]      s_ready
);

  // A zero timeout still needs a legal one-bit counter; it is held at zero.
  localparam int               CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TMO_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  logic [N_SLAVES-1:0] i_hit, d_hit;     // raw decode hits
  logic [N_SLAVES-1:0] i_sel, d_sel;     // one-hot, lowest hitting index
  logic [N_SLAVES-1:0] i_treq, d_treq;   // legal per-target requests
  logic [N_SLAVES-1:0] i_go, d_go;       // per-target completion for each host
  logic                i_bad, d_bad;     // unmapped / exec-violation request
  logic                i_tmo, d_tmo;     // timeout firing this cycle
  logic                i_gnt_raw, d_gnt_raw;
  logic [CNT_W-1:0]    i_cnt, d_cnt;
  logic [31:0]         i_rsel, d_rsel;   // read data of the completing target

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < N_SLAVES; k++) begin : g_hit
    assign i_hit[k] = (i_addr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32];
    assign d_hit[k] = (d_addr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32];
  end

  // Descending scan so the lowest hitting index is the last one written.
  always_comb begin
    i_sel = '0;
    d_sel = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if (i_hit[k]) begin
        i_sel    = '0;
        i_sel[k] = 1'b1;
      end
      if (d_hit[k]) begin
        d_sel    = '0;
        d_sel[k] = 1'b1;
      end
    end
  end

  assign i_treq = {N_SLAVES{i_req}} & i_sel & SLAVE_EXEC;
  assign d_treq = {N_SLAVES{d_req}} & d_sel;
  assign i_bad  = i_req & ~(|(i_sel & SLAVE_EXEC));
  assign d_bad  = d_req & ~(|d_sel);

  assign i_tmo  = TMO_EN && i_req && (i_cnt == CNT_MAX);
  assign d_tmo  = TMO_EN && d_req && (d_cnt == CNT_MAX);

  assign i_gnt_raw = (|i_go) | i_bad | i_tmo;
  assign d_gnt_raw = (|d_go) | d_bad | d_tmo;

  // Grants are combinational; reset masks them immediately.
  assign i_gnt = i_gnt_raw & ~reset;
  assign d_gnt = d_gnt_raw & ~reset;

  // --------------------------------------------------------------------------
  // Per-host wait counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_cnt <= '0;
      d_cnt <= '0;
    end else begin
      i_cnt <= (!TMO_EN || !i_req || i_gnt_raw) ? '0 : i_cnt + CNT_W'(1);
      d_cnt <= (!TMO_EN || !d_req || d_gnt_raw) ? '0 : d_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Per-target ownership and request steering
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < N_SLAVES; k++) begin : g_tgt
    owner_t owner, owner_nxt, eff;
    logic   rr_d, rr_d_nxt;   // 1: data host wins the next contested arbitration
    logic   sv;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        owner <= OWN_NONE;
        rr_d  <= 1'b1;
      end else begin
        owner <= owner_nxt;
        rr_d  <= rr_d_nxt;
      end
    end

    // eff is the owner for this cycle: the held owner while it still
    // requests, otherwise the result of a fresh arbitration. A withdrawn
    // owner therefore frees the target in the same cycle.
    always_comb begin
      eff       = OWN_NONE;
      owner_nxt = owner;
      rr_d_nxt  = rr_d;
      sv        = 1'b0;
      case (owner)
        OWN_I:   if (i_treq[k]) eff = OWN_I;
        OWN_D:   if (d_treq[k]) eff = OWN_D;
        default: ;
      endcase
      if (eff == OWN_NONE) begin
        if (i_treq[k] && d_treq[k]) begin
          eff      = rr_d ? OWN_D : OWN_I;
          rr_d_nxt = ~rr_d;
        end else if (i_treq[k]) begin
          eff = OWN_I;
        end else if (d_treq[k]) begin
          eff = OWN_D;
        end
      end
      case (eff)
        OWN_I:   sv = ~i_tmo;
        OWN_D:   sv = ~d_tmo;
        default: sv = 1'b0;
      endcase
      owner_nxt = eff;
      if ((eff == OWN_I && (i_tmo || s_ready[k])) ||
          (eff == OWN_D && (d_tmo || s_ready[k])))
        owner_nxt = OWN_NONE;
    end

    assign s_valid[k] = sv & ~reset;
    assign i_go[k]    = (eff == OWN_I) & sv & s_ready[k];
    assign d_go[k]    = (eff == OWN_D) & sv & s_ready[k];

    assign s_addr[32*k +: 32]  = (eff == OWN_I) ? i_addr :
                                 (eff == OWN_D) ? d_addr : 32'h0;
    assign s_wdata[32*k +: 32] = (eff == OWN_D) ? d_wdata : 32'h0;
    assign s_wstrb[4*k +: 4]   = (eff == OWN_D && d_we) ? d_be : 4'b0000;
  end

  // --------------------------------------------------------------------------
  // Response capture
  // --------------------------------------------------------------------------
  always_comb begin
    i_rsel = 32'h0;
    d_rsel = 32'h0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (i_go[k]) i_rsel = i_rsel | s_rdata[32*k +: 32];
      if (d_go[k]) d_rsel = d_rsel | s_rdata[32*k +: 32];
    end
  end

  // rdata/err only update on a grant so they hold between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      i_rdata  <= 32'h0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= 32'h0;
    end else begin
      i_rvalid <= i_gnt_raw;
      d_rvalid <= d_gnt_raw;
      if (i_gnt_raw) begin
        i_err   <= i_bad | i_tmo;
        i_rdata <= (|i_go) ? i_rsel : 32'h0;
      end
      if (d_gnt_raw) begin
        d_err   <= d_bad | d_tmo;
        d_rdata <= ((|d_go) && !d_we) ? d_rsel : 32'h0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_fabric
// Description : Self-checking bench for bus_fabric (TIMEOUT_CYCLES = 4).
//               Directed scenarios followed by randomized single-host
//               transfers checked against a latency/response model derived
//               from the decode table and timeout rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_fabric;

  localparam int TMO = 4;

  logic         clk, reset;
  logic         i_req;
  logic [31:0]  i_addr;
  logic         i_gnt, i_rvalid, i_err;
  logic [31:0]  i_rdata;
  logic         d_req, d_we;
  logic [3:0]   d_be;
  logic [31:0]  d_addr, d_wdata;
  logic         d_gnt, d_rvalid, d_err;
  logic [31:0]  d_rdata;
  logic [3:0]   s_valid, s_ready;
  logic [127:0] s_addr, s_wdata, s_rdata;
  logic [15:0]  s_wstrb;

  logic [31:0]  base_a [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h4000_0000};
  logic [31:0]  mask_a [4] = '{32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_F000};
  logic [3:0]   exec_v     = 4'b0001;
  logic [31:0]  tdata  [4];

  int vectors     = 0;
  int miscompares = 0;

  assign s_rdata = {tdata[3], tdata[2], tdata[1], tdata[0]};

  bus_fabric #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < 4; k++)
      if ((a & mask_a[k]) == base_a[k]) return k;
    return -1;
  endfunction

  // One transfer from a single host. w = cycles before the target asserts
  // ready. Expected grant cycle and response come from the rules: errors
  // are granted at once, a wait of TMO or more cycles times out at cycle TMO.
  task automatic txn(input bit is_d, input logic [31:0] addr, input bit we,
                     input logic [3:0] be, input logic [31:0] wd, input int w);
    int          tgt, gcyc;
    bit          ok, timeout, err_exp;
    logic [31:0] rexp;
    logic [3:0]  vexp;
    string       h;
    h       = is_d ? "d" : "i";
    tgt     = decode(addr);
    ok      = 1'b0;
    if (tgt >= 0) ok = is_d || exec_v[tgt];
    timeout = ok && (w >= TMO);
    gcyc    = !ok ? 0 : (timeout ? TMO : w);
    err_exp = !ok || timeout;
    rexp    = 32'h0;
    if (!err_exp && !(is_d && we)) rexp = tdata[tgt];

    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int c = 0; c <= gcyc; c++) begin
      s_ready = 4'b0000;
      if (ok && c >= w) s_ready[tgt] = 1'b1;
      @(negedge clk);
      check({h, "_gnt"}, is_d ? d_gnt : i_gnt, (c == gcyc));
      vexp = 4'b0000;
      if (ok && !(timeout && c == gcyc)) vexp[tgt] = 1'b1;
      check({h, "_s_valid"}, s_valid, vexp);
      if (vexp != 4'b0000) begin
        check({h, "_s_addr"}, s_addr[32*tgt +: 32], addr);
        check({h, "_s_wstrb"}, s_wstrb[4*tgt +: 4], (is_d && we) ? be : 4'b0000);
        if (is_d && we) check("d_s_wdata", s_wdata[32*tgt +: 32], wd);
      end
      if (c < gcyc) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; s_ready = 4'b0000;
    @(negedge clk);
    check({h, "_rvalid"}, is_d ? d_rvalid : i_rvalid, 1);
    check({h, "_err"}, is_d ? d_err : i_err, err_exp);
    check({h, "_rdata"}, is_d ? d_rdata : i_rdata, rexp);
    check("other_rvalid", is_d ? i_rvalid : d_rvalid, 0);
  endtask

  initial begin
    logic [31:0] addr, wd;
    int          cls;
    bit          hd, we;
    logic [3:0]  be;

    reset = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    s_ready = 4'b0000;
    for (int k = 0; k < 4; k++) tdata[k] = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_i_gnt", i_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_i_rvalid", i_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_i_err", i_err, 0);
    check("rst_d_err", d_err, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_s_valid", s_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int k = 0; k < 4; k++) tdata[k] = $urandom;
    tdata[2] = 32'hDEAD_BEEF;
    txn(1'b1, 32'h2000_0010, 1'b0, 4'hF, 32'h0, 0);          // zero-wait RAM read
    txn(1'b1, 32'h8000_0000, 1'b0, 4'hF, 32'h0, 0);          // unmapped
    txn(1'b0, 32'h1000_0000, 1'b0, 4'hF, 32'h0, 0);          // exec violation
    txn(1'b1, 32'h4000_0000, 1'b0, 4'hF, 32'h0, 100);        // GPIO timeout
    txn(1'b0, 32'h0000_0100, 1'b0, 4'hF, 32'h0, 0);          // instruction unaffected
    txn(1'b1, 32'h2000_0040, 1'b1, 4'b0101, $urandom, 1);    // RAM write, 1 wait
    txn(1'b0, 32'h0000_0204, 1'b0, 4'hF, 32'h0, 3);          // ROM fetch, 3 waits

    // Contention on ROM: D wins first, then I on the next contested access.
    tdata[0] = $urandom;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h0000_0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
    for (int c = 0; c < 4; c++) begin
      s_ready = (c >= 2) ? 4'b0001 : 4'b0000;
      if (c == 3) d_req = 1'b0;
      @(negedge clk);
      check("rrA_i_gnt", i_gnt, (c == 3));
      check("rrA_d_gnt", d_gnt, (c == 2));
      check("rrA_s_addr", s_addr[31:0], (c == 3) ? 32'h0000_0100 : 32'h0000_0200);
      if (c == 3) check("rrA_d_rdata", d_rdata, tdata[0]);
      @(posedge clk); #1;
    end
    i_req = 1'b0; s_ready = 4'b0000;
    @(negedge clk);
    check("rrA_i_rvalid", i_rvalid, 1);
    check("rrA_i_rdata", i_rdata, tdata[0]);
    @(posedge clk); #1;
    i_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      s_ready = (c >= 2) ? 4'b0001 : 4'b0000;
      if (c == 3) i_req = 1'b0;
      @(negedge clk);
      check("rrB_i_gnt", i_gnt, (c == 2));
      check("rrB_d_gnt", d_gnt, (c == 3));
      check("rrB_s_addr", s_addr[31:0], (c == 3) ? 32'h0000_0200 : 32'h0000_0100);
      @(posedge clk); #1;
    end
    d_req = 1'b0; s_ready = 4'b0000;
    @(negedge clk);
    check("rrB_d_rvalid", d_rvalid, 1);
    check("rrB_d_err", d_err, 0);

    // Independent hosts granted in the same cycle on different targets.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h0000_0300;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h2000_0300; d_wdata = $urandom;
    s_ready = 4'b0101;
    @(negedge clk);
    check("dual_i_gnt", i_gnt, 1);
    check("dual_d_gnt", d_gnt, 1);
    check("dual_s_valid", s_valid, 4'b0101);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; s_ready = 4'b0000;
    @(negedge clk);
    check("dual_i_rdata", i_rdata, tdata[0]);
    check("dual_d_rvalid", d_rvalid, 1);
    check("dual_d_rdata", d_rdata, 0);

    // Reset in the middle of a stalled FRAM write.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h1000_0004; d_wdata = $urandom;
    @(negedge clk);
    check("rstm_s_valid_pre", s_valid, 4'b0010);
    check("rstm_wstrb_pre", s_wstrb[7:4], 4'b0011);
    #2 reset = 1'b1;
    #1;
    check("rstm_s_valid", s_valid, 0);
    check("rstm_d_gnt", d_gnt, 0);
    check("rstm_d_rvalid", d_rvalid, 0);
    check("rstm_d_err", d_err, 0);
    check("rstm_d_rdata", d_rdata, 0);
    check("rstm_i_rdata", i_rdata, 0);
    d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("rstm_no_rvalid", d_rvalid, 0);
    end

    // Randomized single-host transfers.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++) tdata[k] = $urandom;
      cls = $urandom_range(0, 4);
      if (cls == 4) addr = 32'h8000_0000 | ($urandom & 32'h00FF_FFFC);
      else          addr = base_a[cls] | ($urandom & ~mask_a[cls]);
      hd = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      txn(hd, addr, we, be, wd, $urandom_range(0, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
